// File: rtl/food_map_pkg.sv
// Shared constants, FSM encoding and helpers for the food map renderer.
package food_map_pkg;

    // VGA timing
    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int V_TOTAL    = 525;

    // Food map geometry
    localparam int TILE_SHIFT = 3;
    localparam int MAP_COLS   = 80;
    localparam int MAP_ROWS   = 60;
    localparam int ROW_W      = 6;   // width of a food map row address
    localparam int CNT_W      = 13;  // holds up to MAP_COLS * MAP_ROWS = 4800

    // Port-B read latency (cycles from food_read_en to valid food_row)
    localparam int RD_LAT     = 1;

    // In-tile offsets (x and y) that make up the drawn dot
    localparam int DOT_LO     = 3;
    localparam int DOT_HI     = 4;

    // Serial popcount slicing
    localparam int SLICE_W    = 8;
    localparam int N_SLICES   = MAP_COLS / SLICE_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_COUNT = 3'd4
    } fetch_state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/food_map_renderer_if.sv
// Port-B read bus between the renderer (master) and the dual-port food map RAM (slave).
// Handshake: the master holds food_map_read_y and pulses food_read_en for exactly one
// cycle; the RAM presents the addressed row on food_row RD_LAT cycles later and keeps
// it stable until the next enable. There is no back-pressure.
interface food_map_renderer_if;

    logic [food_map_pkg::ROW_W-1:0]    food_map_read_y;
    logic                              food_read_en;
    logic [food_map_pkg::MAP_COLS-1:0] food_row;

    modport master (
        output food_map_read_y,
        output food_read_en,
        input  food_row
    );

    modport slave (
        input  food_map_read_y,
        input  food_read_en,
        output food_row
    );

endinterface

// File: rtl/food_row_popcount.sv
// Serial popcount of one food row: one 8-bit slice per cycle over N_SLICES cycles.
// A start pulse latches the row; done is high in the final slice cycle, and result
// (the row's total) is valid in that same cycle.
module food_row_popcount
    import food_map_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [MAP_COLS-1:0] row_in,
    output logic                done,
    output logic [CNT_W-1:0]    result
);

    logic [MAP_COLS-1:0] data_q;
    logic [3:0]          idx;
    logic [6:0]          sum;
    logic                busy;
    logic [SLICE_W-1:0]  slice;
    logic [3:0]          slice_cnt;

    // Current slice and its popcount; the last slice is folded into result directly.
    always_comb begin
        slice     = data_q[{idx, 3'b000} +: SLICE_W];
        slice_cnt = popcount8(slice);
        done      = busy && (idx == 4'(N_SLICES - 1));
        result    = CNT_W'(sum) + CNT_W'(slice_cnt);
    end

    // Latch the row on start, then walk the slices accumulating the running sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            idx    <= '0;
            sum    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            data_q <= row_in;
            idx    <= '0;
            sum    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            sum <= sum + 7'(slice_cnt);
            if (done) begin
                idx  <= '0;
                busy <= 1'b0;
            end else begin
                idx <= idx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/food_map_renderer.sv
// Fetches one food row per tile row during horizontal blanking, holds it in a line
// buffer, emits a per-pixel food-dot flag one cycle behind the pixel stream, and
// counts the remaining food over each complete frame.
module food_map_renderer
    import food_map_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [10:0]          pix_x,
    input  logic [9:0]           pix_y,
    input  logic                 pix_active,
    food_map_renderer_if.master  port_b,
    output logic                 food_pixel,
    output logic                 food_pixel_valid,
    output logic [CNT_W-1:0]     food_remaining,
    output logic                 count_valid,
    output logic                 level_clear,
    output logic                 fetch_overrun,
    output fetch_state_t         state_dbg
);

    fetch_state_t        state, nstate;
    logic [9:0]          next_y;
    logic                trigger;
    logic [ROW_W-1:0]    target_row;
    logic [ROW_W-1:0]    row_addr;
    logic [1:0]          wait_cnt;
    logic [MAP_COLS-1:0] line_buf;
    logic                pc_start;
    logic                pc_done;
    logic [CNT_W-1:0]    pc_result;
    logic [CNT_W-1:0]    acc;
    logic [CNT_W-1:0]    frame_sum;
    logic [6:0]          rows_seen;
    logic [6:0]          rows_seen_nxt;
    logic [7:0]          col;
    logic                in_map;
    logic                dot_x;
    logic                dot_y;
    logic                lb_bit;

    // Fetch trigger: at the first blanking pixel of the line before a new tile row.
    always_comb begin
        next_y     = (pix_y == 10'(V_TOTAL - 1)) ? 10'd0 : pix_y + 10'd1;
        trigger    = (pix_x == 11'(H_ACTIVE)) && (next_y < 10'(V_ACTIVE)) &&
                     (next_y[TILE_SHIFT-1:0] == '0);
        target_row = next_y[TILE_SHIFT +: ROW_W];
    end

    // Fetch FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Fetch FSM next state; the popcount is kicked off in the capture cycle.
    always_comb begin
        nstate   = state;
        pc_start = 1'b0;
        case (state)
            ST_IDLE:  if (trigger) nstate = ST_REQ;
            ST_REQ:   nstate = ST_WAIT;
            ST_WAIT:  if (wait_cnt == 2'(RD_LAT - 1)) nstate = ST_CAPT;
            ST_CAPT: begin
                nstate   = ST_COUNT;
                pc_start = 1'b1;
            end
            ST_COUNT: if (pc_done) nstate = ST_IDLE;
            default:  nstate = ST_IDLE;
        endcase
    end

    assign port_b.food_read_en    = (state == ST_REQ);
    assign port_b.food_map_read_y = row_addr;
    assign state_dbg              = state;

    // Row address is latched when a fetch is accepted and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_addr <= '0;
        end else if (state == ST_IDLE && trigger) begin
            row_addr <= target_row;
        end
    end

    // Count the cycles spent waiting on the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 2'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // A trigger that lands while a fetch is in flight is dropped and remembered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_overrun <= 1'b0;
        end else if (trigger && state != ST_IDLE) begin
            fetch_overrun <= 1'b1;
        end
    end

    // Line buffer takes the returned row in the capture cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_buf <= '0;
        end else if (state == ST_CAPT) begin
            line_buf <= port_b.food_row;
        end
    end

    food_row_popcount u_popcount (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (pc_start),
        .row_in (port_b.food_row),
        .done   (pc_done),
        .result (pc_result)
    );

    assign frame_sum     = acc + pc_result;
    assign rows_seen_nxt = rows_seen + 7'd1;

    // Frame accounting: publish only when every row of the frame was counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc            <= '0;
            rows_seen      <= '0;
            food_remaining <= '0;
            count_valid    <= 1'b0;
        end else if (state == ST_COUNT && pc_done) begin
            if (row_addr == ROW_W'(MAP_ROWS - 1)) begin
                if (rows_seen_nxt == 7'(MAP_ROWS)) begin
                    food_remaining <= frame_sum;
                    count_valid    <= 1'b1;
                end
                acc       <= '0;
                rows_seen <= '0;
            end else begin
                acc       <= frame_sum;
                rows_seen <= rows_seen_nxt;
            end
        end
    end

    assign level_clear = count_valid && (food_remaining == '0);

    // Dot decode for the current pixel; columns beyond the map never draw.
    always_comb begin
        col    = pix_x[10:TILE_SHIFT];
        in_map = (col < 8'(MAP_COLS));
        lb_bit = in_map ? line_buf[col[6:0]] : 1'b0;
        dot_x  = (pix_x[TILE_SHIFT-1:0] >= 3'(DOT_LO)) && (pix_x[TILE_SHIFT-1:0] <= 3'(DOT_HI));
        dot_y  = (pix_y[TILE_SHIFT-1:0] >= 3'(DOT_LO)) && (pix_y[TILE_SHIFT-1:0] <= 3'(DOT_HI));
    end

    // Pixel pipe, one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            food_pixel       <= 1'b0;
            food_pixel_valid <= 1'b0;
        end else begin
            food_pixel       <= pix_active && lb_bit && dot_x && dot_y;
            food_pixel_valid <= pix_active;
        end
    end

endmodule

// File: tb/tb_food_map_renderer.sv
// Directed bench for food_map_renderer: a RAM model answers port-B reads, stimulus
// pushes expected fetch rows and pixel flags into queues, and a monitor pops them
// whenever the DUT presents a read or a valid pixel.
module tb_food_map_renderer;
    import food_map_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [10:0]  pix_x;
    logic [9:0]   pix_y;
    logic         pix_active;
    logic         food_pixel;
    logic         food_pixel_valid;
    logic [12:0]  food_remaining;
    logic         count_valid;
    logic         level_clear;
    logic         fetch_overrun;
    fetch_state_t state_dbg;

    food_map_renderer_if bus ();

    food_map_renderer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .pix_active       (pix_active),
        .port_b           (bus),
        .food_pixel       (food_pixel),
        .food_pixel_valid (food_pixel_valid),
        .food_remaining   (food_remaining),
        .count_valid      (count_valid),
        .level_clear      (level_clear),
        .fetch_overrun    (fetch_overrun),
        .state_dbg        (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM model (port B, 1-cycle read) ----------------
    logic [79:0] ram [0:59];

    always @(posedge clk) begin
        if (bus.food_read_en) bus.food_row <= ram[bus.food_map_read_y];
    end

    // ---------------- scoreboard ----------------
    int         n_vec  = 0;
    int         n_fail = 0;
    logic [5:0] exp_addr_q[$];
    logic [0:0] exp_pix_q[$];
    logic [5:0] e_row;
    logic [0:0] e_pix;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation each time the DUT issues a read or a valid pixel.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.food_read_en === 1'b1) begin
            n_vec++;
            if (exp_addr_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: got row %0d, expected no fetch", bus.food_map_read_y);
            end else begin
                e_row = exp_addr_q.pop_front();
                if (bus.food_map_read_y !== e_row) begin
                    n_fail++;
                    $display("FAIL read_row: got %0d, expected %0d", bus.food_map_read_y, e_row);
                end
            end
        end
        if (rst_n === 1'b1 && food_pixel_valid === 1'b1) begin
            n_vec++;
            if (exp_pix_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pixel: got valid pixel %0b, expected none", food_pixel);
            end else begin
                e_pix = exp_pix_q.pop_front();
                if (food_pixel !== e_pix[0]) begin
                    n_fail++;
                    $display("FAIL food_pixel: got %0b, expected %0b (x=%0d y=%0d prev cycle)",
                             food_pixel, e_pix[0], pix_x, pix_y);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        pix_x      = 11'd0;
        pix_y      = 10'd0;
        pix_active = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_en"},     bus.food_read_en, 0);
        check({tag, "_read_y"},      bus.food_map_read_y, 0);
        check({tag, "_pixel"},       food_pixel, 0);
        check({tag, "_pixel_valid"}, food_pixel_valid, 0);
        check({tag, "_remaining"},   food_remaining, 0);
        check({tag, "_count_valid"}, count_valid, 0);
        check({tag, "_level_clear"}, level_clear, 0);
        check({tag, "_overrun"},     fetch_overrun, 0);
        check({tag, "_state_idle"},  state_dbg == ST_IDLE, 1);
        check({tag, "_line_buf"},    dut.line_buf, 0);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (state_dbg != ST_IDLE && cyc < 150) begin
            tick();
            cyc++;
        end
        check("fetch_within_blanking", cyc < 150, 1);
    endtask

    // One blanking-start cycle at line y; expect_trig says whether a fetch of row must follow.
    task automatic do_fetch(input int y, input bit expect_trig, input int row);
        pix_x      = 11'd640;
        pix_y      = 10'(y);
        pix_active = 1'b0;
        if (expect_trig) exp_addr_q.push_back(6'(row));
        tick();
        pix_x = 11'd641;
        if (expect_trig) begin
            wait_idle();
        end else begin
            check("no_trigger_state", state_dbg == ST_IDLE, 1);
        end
    endtask

    task automatic fetch_row(input int r);
        do_fetch((r == 0) ? 524 : 8 * r - 1, 1'b1, r);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) fetch_row(r);
    endtask

    task automatic drive_pix(input int x, input int y, input bit exp);
        pix_x      = 11'(x);
        pix_y      = 10'(y);
        pix_active = 1'b1;
        exp_pix_q.push_back(exp);
        tick();
    endtask

    task automatic fill_ram(input logic [79:0] v);
        for (int i = 0; i < 60; i++) ram[i] = v;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < 60; i++) ram[i] = {10{8'(i * 7 + 1)}};
        rst_n      = 1'b0;
        pix_x      = 11'd0;
        pix_y      = 10'd0;
        pix_active = 1'b0;
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fetch triggers, row addresses and line buffer contents.
        do_fetch(7, 1'b1, 1);
        check("line_buf_row1", dut.line_buf, ram[1]);
        check("read_y_held", bus.food_map_read_y, 1);
        do_fetch(8, 1'b0, 0);
        do_fetch(479, 1'b0, 0);
        do_fetch(523, 1'b0, 0);
        do_fetch(524, 1'b1, 0);
        check("line_buf_row0", dut.line_buf, ram[0]);
        do_fetch(471, 1'b1, 59);
        check("line_buf_row59", dut.line_buf, ram[59]);

        // Trigger during WAIT is dropped; in-flight fetch of row 1 is unaffected.
        ram[1] = 80'hA5A5_A5A5_A5A5_A5A5_A5A5;
        ram[2] = 80'h5A5A_5A5A_5A5A_5A5A_5A5A;
        check("overrun_clear_before", fetch_overrun, 0);
        pix_x = 11'd640;
        pix_y = 10'd7;
        exp_addr_q.push_back(6'd1);
        tick();
        pix_x = 11'd641;
        for (int c = 0; c < 10 && state_dbg != ST_WAIT; c++) tick();
        check("reached_wait", state_dbg == ST_WAIT, 1);
        pix_x = 11'd640;
        pix_y = 10'd15;
        tick();
        pix_x = 11'd641;
        check("overrun_set", fetch_overrun, 1);
        wait_idle();
        check("overrun_line_buf", dut.line_buf, 80'hA5A5_A5A5_A5A5_A5A5_A5A5);
        check("overrun_read_y", bus.food_map_read_y, 1);
        check("overrun_sticky", fetch_overrun, 1);

        // Dot rendering from row 0 = 80'h1.
        ram[0] = 80'h1;
        fetch_row(0);
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 16; x++) begin
                drive_pix(x, y, (x == 3 || x == 4) && (y == 3 || y == 4));
            end
        end
        for (int x = 632; x < 640; x++) drive_pix(x, 3, 1'b0);
        pix_x      = 11'd3;
        pix_y      = 10'd3;
        pix_active = 1'b0;
        tick();
        check("inactive_pixel", food_pixel, 0);
        check("inactive_valid", food_pixel_valid, 0);

        // Right-edge column and beyond-map columns with a full row.
        ram[59] = {80{1'b1}};
        fetch_row(59);
        drive_pix(635, 3, 1'b1);
        drive_pix(636, 4, 1'b1);
        drive_pix(637, 4, 1'b0);
        drive_pix(634, 3, 1'b0);
        drive_pix(643, 3, 1'b0);
        drive_pix(644, 4, 1'b0);
        drive_pix(3, 5, 1'b0);
        pix_active = 1'b0;
        tick();
        tick();

        // Full map of ones for two frames.
        do_reset();
        fill_ram({80{1'b1}});
        run_rows(0, 59);
        run_rows(0, 59);
        check("full_remaining", food_remaining, 4800);
        check("full_count_valid", count_valid, 1);
        check("full_level_clear", level_clear, 0);

        // All-zero frame: result only changes once row 59 is counted.
        fill_ram(80'h0);
        run_rows(0, 58);
        check("zero_pre59_remaining", food_remaining, 4800);
        check("zero_pre59_level_clear", level_clear, 0);
        fetch_row(59);
        check("zero_remaining", food_remaining, 0);
        check("zero_count_valid", count_valid, 1);
        check("zero_level_clear", level_clear, 1);

        // Mixed frame: even rows 4 dots (top slice), odd rows 5 dots -> 270.
        for (int i = 0; i < 60; i++) begin
            ram[i] = (i % 2 == 0) ? 80'hF000_0000_0000_0000_0000 : 80'h0000_0000_0101_0000_0007;
        end
        run_rows(0, 59);
        check("mixed_remaining", food_remaining, 270);
        check("mixed_level_clear", level_clear, 0);

        // Reset at COUNT cycle 4 of row 59; the interrupted frame never publishes.
        do_reset();
        fill_ram({80{1'b1}});
        run_rows(0, 58);
        pix_x = 11'd640;
        pix_y = 10'd471;
        exp_addr_q.push_back(6'd59);
        tick();
        pix_x = 11'd641;
        for (int c = 0; c < 10 && state_dbg != ST_COUNT; c++) tick();
        check("reached_count", state_dbg == ST_COUNT, 1);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midcount_reset");
        tick();
        rst_n = 1'b1;
        tick();
        fetch_row(59);
        check("partial_count_valid", count_valid, 0);
        check("partial_remaining", food_remaining, 0);
        check("partial_level_clear", level_clear, 0);

        tick();
        tick();
        check("addr_q_drained", exp_addr_q.size(), 0);
        check("pix_q_drained", exp_pix_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
